stream_mux_rr: RTL
==================

# stream_mux_rr

Parametrised N-input, W-bit valid/ready stream multiplexer with a one-beat registered output stage. Each cycle in which the output register can accept a beat, one input is granted, either by an external select (fixed mode) or by a round-robin arbiter (RR mode). The granted beat is transferred to the output register. This is the sequential, handshaked generalisation of the 2:1 and 4:1 data muxes, and it sits between several producers and a single consumer.

## Interface
- `N_IN`, default 4: number of input channels, ≥2, any value (not required to be a power of two).
- `W`, default 4: data width in bits, ≥1.
- `SEL_W`, default `$clog2(N_IN)`: select/source index width; derived, do not override.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous reset, active-low.
- `in_valid`, input, N_IN: per-channel valid.
- `in_data`, input, N_IN*W: channel i occupies bits [i*W +: W].
- `in_ready`, output, N_IN: per-channel ready, one-hot or zero.
- `mode`, input, 1: 0 = fixed select, 1 = round-robin.
- `sel`, input, SEL_W: channel index used in fixed mode.
- `out_valid`, output, 1: output register holds a beat.
- `out_data`, output, W: registered data.
- `out_src`, output, SEL_W: index of the channel that supplied the held beat.
- `out_ready`, input, 1: consumer accepts.

## Operation
- Define `free = !out_valid || out_ready`. A grant decision is made only when `free` is 1.
- Fixed mode: the grant candidate is `sel`. The grant is valid only if `sel < N_IN` and `in_valid[sel]` is 1. `sel ≥ N_IN` produces no grant.
- RR mode: 3-bit-style priority scan starting at `ptr+1` (mod N_IN) and wrapping. The first channel with `in_valid` set is granted.
- `in_ready[g] = rst && free && grant_valid`. All other `in_ready` bits are 0, and all bits are 0 while `rst` is low.
- An input transfer occurs on `in_valid[g] && in_ready[g]`. On that edge: `out_data <= in_data[g]`, `out_src <= g`, `out_valid <= 1`, `ptr <= g`. The pointer updates on every accepted transfer in either mode.
- Output handshake: if `out_valid && out_ready` and no new transfer occurs, `out_valid <= 0`. If a new transfer occurs, the register is overwritten in the same cycle, giving full throughput of 1 beat/cycle.
- While `out_valid && !out_ready`, `out_data` and `out_src` are held stable and all `in_ready` are 0.
- `mode` and `sel` changes take effect at the next grant decision. A held beat is never altered.
- Inputs may drop `in_valid` without a transfer. No input-side stability is assumed.

## Timing
- Reset (rst low at an edge): `out_valid=0`, `out_data=0`, `out_src=0`, `ptr=N_IN-1`, so channel 0 has first RR priority. Reset mid-transfer discards the held beat. A beat offered in the reset cycle is not accepted.
- Latency: an input accepted at edge k appears on `out_*` after edge k, and is visible in cycle k+1.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode`, and `sel`. There is no combinational path from `in_data` to any output.
- RR fairness: with all channels continuously valid and `out_ready=1`, grants cycle 0,1,…,N_IN-1,0,…, one per cycle.
- Simultaneous output drain and input accept in one cycle yields no bubble.

## Configuration
- `STREAM_MUX_RR_EN` defined: the arbiter and `ptr` are compiled in, and `mode` is honoured as above.
- Not defined: the `mode` port remains but is ignored, fixed-select behaviour only. The `ptr` register is omitted. All other timing is identical.

## Test plan
- Reset: hold `rst=0` for 3 cycles with all `in_valid=1` → `out_valid=0`, `out_data=0`, `out_src=0`, `in_ready=0` throughout. After release, with `mode=1`, the first grant is channel 0.
- Fixed select, N_IN=4, W=4: `mode=0`, `sel=2`, `in_data[2]=4'hA`, `in_valid=4'b0100`, `out_ready=1` → `in_ready=4'b0100`. The next cycle shows `out_valid=1`, `out_data=4'hA`, `out_src=2`. With `sel=3` and `in_valid[3]=0`, there is no grant.
- Round-robin streaming: `mode=1`, all valid, `out_ready=1` for 8 cycles → `out_src` sequence 0,1,2,3,0,1,2,3 with no bubbles. With `in_valid=4'b1010`, the sequence is 1,3,1,3.
- Backpressure: hold `out_valid=1`, `out_data=4'h5`, and drop `out_ready` to 0 for 4 cycles → `in_ready=0`, and `out_data`/`out_src` stay stable. On `out_ready=1`, a same-cycle drain and accept gives the new beat on the next cycle.
- Out-of-range select, N_IN=3: `mode=0`, `sel=3` → `in_ready=0`, and `out_valid` falls after the pending beat drains.
- Macro off: recompile without `STREAM_MUX_RR_EN`, set `mode=1`, `sel=1` → only channel 1 is ever granted.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream multiplexer with a one-beat registered output stage.
// Define STREAM_MUX_RR_EN to build in the round-robin arbiter; otherwise only fixed select is used.
module stream_mux_rr #(
    parameter int N_IN  = 4,
    parameter int W     = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_IN-1:0]     i_in_valid,
    input  logic [N_IN*W-1:0]   i_in_data,
    output logic [N_IN-1:0]     o_in_ready,
    input  logic                i_mode,
    input  logic [SEL_W-1:0]    i_sel,
    output logic                o_out_valid,
    output logic [W-1:0]        o_out_data,
    output logic [SEL_W-1:0]    o_out_src,
    input  logic                i_out_ready
);

    logic               r_out_valid;
    logic [W-1:0]       r_out_data;
    logic [SEL_W-1:0]   r_out_src;

    logic               w_free;
    logic               w_fix_valid;
    logic               w_grant_valid;
    logic [SEL_W-1:0]   w_grant_idx;
    logic [W-1:0]       w_grant_data;
    logic               w_xfer;

    assign w_free = !r_out_valid || i_out_ready;

    // A select value with no matching channel leaves w_fix_valid low, which covers sel >= N_IN.
    always_comb begin
        w_fix_valid = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (i_sel == SEL_W'(i)) begin
                w_fix_valid = i_in_valid[i];
            end
        end
    end

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0]   r_ptr;
    logic               w_rr_valid;
    logic [SEL_W-1:0]   w_rr_idx;
    int                 w_rr_dist;
    int                 w_rr_best;

    // Rank each valid channel by its distance after the pointer; the closest one wins.
    always_comb begin
        w_rr_valid = 1'b0;
        w_rr_idx   = '0;
        w_rr_best  = N_IN;
        w_rr_dist  = 0;
        for (int c = 0; c < N_IN; c++) begin
            w_rr_dist = (c + 2 * N_IN - int'(r_ptr) - 1) % N_IN;
            if (i_in_valid[c] && (w_rr_dist < w_rr_best)) begin
                w_rr_best  = w_rr_dist;
                w_rr_valid = 1'b1;
                w_rr_idx   = SEL_W'(c);
            end
        end
    end

    assign w_grant_valid = i_mode ? w_rr_valid : w_fix_valid;
    assign w_grant_idx   = i_mode ? w_rr_idx   : i_sel;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ptr <= SEL_W'(N_IN - 1);
        end else if (w_xfer) begin
            r_ptr <= w_grant_idx;
        end
    end
`else
    logic               w_unused_mode;

    assign w_unused_mode = i_mode;
    assign w_grant_valid = w_fix_valid;
    assign w_grant_idx   = i_sel;
`endif

    assign w_xfer = i_rst && w_free && w_grant_valid;

    always_comb begin
        w_grant_data = '0;
        o_in_ready   = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_grant_data  = i_in_data[i*W +: W];
                o_in_ready[i] = w_xfer;
            end
        end
    end

    // A new transfer overwrites the held beat in the same cycle it drains, so there is no bubble.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_src   <= w_grant_idx;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_src   = r_out_src;

endmodule
